// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetches byte-wide instructions, decodes operands,
// and drives an external ALU and register file. HALT and FAULT are terminal until reset.
module cpu_sequencer #(
  parameter logic [7:0]  PC_RESET      = 8'h00,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_rdata,
  output logic       rf_rsel,
  input  logic [7:0] rf_rdata,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_result,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       retire,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_JMP  = 3'b110,
    OP_HLT  = 3'b111
  } opcode_t;

  // Last FETCH cycle index before the timeout fires; the counter starts at zero.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  logic [7:0] operand;
  logic [7:0] timeout_cnt;
  opcode_t    opcode;

  assign opcode = opcode_t'(ir[7:5]);

  // Status outputs decode straight from the state register, so an asynchronous
  // reset clears them in the same instant it clears the state.
  assign imem_req  = (state == FETCH);
  assign retire    = (state == EXEC);
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);
  assign imem_addr = pc;
  assign rf_rsel   = ir[0];
  assign alu_a     = acc;
  assign alu_b     = operand;
  assign alu_ctrl  = ir[7:5];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order of statements or processes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          state_next = DECODE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_next = FAULT;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (opcode == OP_HLT) begin
          state_next = HALT;
        end else if (run) begin
          state_next = FETCH;
        end else begin
          state_next = IDLE;
        end
      end
      HALT:    state_next = HALT;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // The counter is held at zero outside FETCH, so every FETCH entry starts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt <= 8'h00;
    end else if (state == FETCH && !imem_ack) begin
      timeout_cnt <= timeout_cnt + 8'h01;
    end else begin
      timeout_cnt <= 8'h00;
    end
  end

  // ir only loads on an acknowledged fetch; acks in any other state are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= 8'h00;
    end else if (state == FETCH && imem_ack) begin
      ir <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand <= 8'h00;
    end else if (state == DECODE) begin
      operand <= ir[4] ? rf_rdata : {4'b0000, ir[3:0]};
    end
  end

  // pc + 1 wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= 8'h00;
      pc  <= PC_RESET;
    end else if (state == EXEC) begin
      case (opcode)
        OP_LOAD: begin
          acc <= operand;
          pc  <= pc + 8'h01;
        end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          acc <= alu_result;
          pc  <= pc + 8'h01;
        end
        OP_JMP: begin
          pc <= operand;
        end
        default: begin
          // HLT leaves pc and acc as they are.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction memory, register file and ALU are
// modelled here; each scenario checks hand-computed values cycle by cycle.
module tb_cpu_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic       rf_rsel;
  logic [7:0] rf_rdata;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic [7:0] pc;
  logic       retire;
  logic       halted;
  logic       fault;

  logic [7:0] mem [256];
  logic [7:0] r0;
  logic [7:0] r1;
  logic       ack_en;
  int         checks;
  int         errors;
  int         retire_cnt;
  int         snap;

  cpu_sequencer #(.PC_RESET(8'h00), .FETCH_TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .rf_rsel    (rf_rsel),
    .rf_rdata   (rf_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .acc        (acc),
    .pc         (pc),
    .retire     (retire),
    .halted     (halted),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory: ack is a plain level, data is read combinationally.
  assign imem_ack   = ack_en;
  assign imem_rdata = mem[imem_addr];
  assign rf_rdata   = rf_rsel ? r1 : r0;

  always_comb begin
    alu_result = alu_b;
    case (alu_ctrl)
      3'b001:  alu_result = alu_a + alu_b;
      3'b010:  alu_result = alu_a - alu_b;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = alu_b;
    endcase
  end

  // retire is level for a whole cycle, so sampling on the falling edge counts each pulse once.
  always @(negedge clk) begin
    if (retire === 1'b1) retire_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    ack_en  = 1'b1;
    r0      = 8'h00;
    r1      = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    run     = 1'b0;
    tick(1);
    reset_n = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00 || acc !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: pc=%h acc=%h, required pc=00 acc=00", pc, acc);
    end
    checks++;
    if ({imem_req, retire, halted, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: req/ret/halt/fault=%b, required 0000", {imem_req, retire, halted, fault});
    end
    checks++;
    if (rf_rsel !== 1'b0 || alu_b !== 8'h00 || alu_ctrl !== 3'b000) begin
      errors++;
      $display("FAIL reset_ir_operand: rsel=%b alu_b=%h ctrl=%b, required 0 00 000", rf_rsel, alu_b, alu_ctrl);
    end
    do_reset();
    tick(2);
    checks++;
    if (imem_req !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL idle_no_run: imem_req=%b pc=%h, required 0 00", imem_req, pc);
    end
  endtask

  task automatic test_load_add_hlt();
    do_reset();
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h23;
    mem[8'h02] = 8'hE0;
    snap = retire_cnt;
    run  = 1'b1;
    tick(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL fetch0: imem_req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
    tick(1);
    checks++;
    if (imem_req !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL decode0: imem_req=%b retire=%b, required 0 0", imem_req, retire);
    end
    tick(1);
    checks++;
    if (retire !== 1'b1 || acc !== 8'h00) begin
      errors++;
      $display("FAIL exec0: retire=%b acc=%h, required 1 00", retire, acc);
    end
    tick(1);
    checks++;
    if (acc !== 8'h05 || pc !== 8'h01 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL after_load: acc=%h pc=%h req=%b, required 05 01 1", acc, pc, imem_req);
    end
    tick(3);
    checks++;
    if (acc !== 8'h08 || pc !== 8'h02) begin
      errors++;
      $display("FAIL after_add: acc=%h pc=%h, required 08 02", acc, pc);
    end
    tick(3);
    checks++;
    if (halted !== 1'b1 || pc !== 8'h02 || acc !== 8'h08 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt: halted=%b pc=%h acc=%h req=%b, required 1 02 08 0", halted, pc, acc, imem_req);
    end
    checks++;
    if (retire_cnt - snap !== 3) begin
      errors++;
      $display("FAIL retire_count: got %0d pulses, required 3", retire_cnt - snap);
    end
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(2);
    checks++;
    if (halted !== 1'b1 || retire !== 1'b0 || pc !== 8'h02 || retire_cnt - snap !== 3) begin
      errors++;
      $display("FAIL halt_sticky: halted=%b retire=%b pc=%h pulses=%0d, required 1 0 02 3",
               halted, retire, pc, retire_cnt - snap);
    end
  endtask

  task automatic test_reg_operand();
    do_reset();
    r1 = 8'h0F;
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h6C;
    run = 1'b1;
    tick(2);
    checks++;
    if (rf_rsel !== 1'b1) begin
      errors++;
      $display("FAIL rsel_decode: rf_rsel=%b, required 1", rf_rsel);
    end
    tick(1);
    checks++;
    if (alu_b !== 8'h0F) begin
      errors++;
      $display("FAIL reg_operand: alu_b=%h, required 0F", alu_b);
    end
    tick(1);
    checks++;
    if (acc !== 8'h0F) begin
      errors++;
      $display("FAIL load_r1: acc=%h, required 0F", acc);
    end
    tick(2);
    checks++;
    if (alu_ctrl !== 3'b011 || alu_b !== 8'h0C) begin
      errors++;
      $display("FAIL and_exec: ctrl=%b alu_b=%h, required 011 0C", alu_ctrl, alu_b);
    end
    tick(1);
    checks++;
    if (acc !== 8'h0C || pc !== 8'h02) begin
      errors++;
      $display("FAIL and_result: acc=%h pc=%h, required 0C 02", acc, pc);
    end
  endtask

  task automatic test_pc_wrap_jmp();
    do_reset();
    r0 = 8'hFE;
    mem[8'h00] = 8'hD0;
    mem[8'hFE] = 8'h21;
    mem[8'hFF] = 8'h21;
    run = 1'b1;
    tick(4);
    checks++;
    if (pc !== 8'hFE || acc !== 8'h00) begin
      errors++;
      $display("FAIL jmp_reg: pc=%h acc=%h, required FE 00", pc, acc);
    end
    mem[8'h00] = 8'hC3;
    mem[8'h03] = 8'hE0;
    tick(3);
    checks++;
    if (pc !== 8'hFF || acc !== 8'h01) begin
      errors++;
      $display("FAIL pc_ff: pc=%h acc=%h, required FF 01", pc, acc);
    end
    tick(3);
    checks++;
    if (pc !== 8'h00 || acc !== 8'h02 || fault !== 1'b0) begin
      errors++;
      $display("FAIL pc_wrap: pc=%h acc=%h fault=%b, required 00 02 0", pc, acc, fault);
    end
    tick(3);
    checks++;
    if (pc !== 8'h03 || acc !== 8'h02) begin
      errors++;
      $display("FAIL jmp_imm: pc=%h acc=%h, required 03 02", pc, acc);
    end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    ack_en = 1'b0;
    run    = 1'b1;
    tick(15);
    checks++;
    if (imem_req !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fetch15: imem_req=%b fault=%b, required 1 0", imem_req, fault);
    end
    tick(1);
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout: fault=%b imem_req=%b, required 1 0", fault, imem_req);
    end
    ack_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      tick(1);
    end
    checks++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || retire !== 1'b0 || pc !== 8'h00) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b req=%b retire=%b pc=%h, required 1 0 0 00",
               fault, imem_req, retire, pc);
    end
  endtask

  task automatic test_run_drop();
    do_reset();
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h23;
    run = 1'b1;
    tick(2);
    run = 1'b0;
    tick(1);
    checks++;
    if (retire !== 1'b1) begin
      errors++;
      $display("FAIL drop_retire: retire=%b, required 1", retire);
    end
    tick(1);
    checks++;
    if (imem_req !== 1'b0 || acc !== 8'h05 || pc !== 8'h01) begin
      errors++;
      $display("FAIL drop_idle: req=%b acc=%h pc=%h, required 0 05 01", imem_req, acc, pc);
    end
    tick(2);
    checks++;
    if (imem_req !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: req=%b retire=%b, required 0 0", imem_req, retire);
    end
    run = 1'b1;
    tick(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL resume: req=%b addr=%h, required 1 01", imem_req, imem_addr);
    end
    ack_en = 1'b0;
    run    = 1'b0;
    tick(2);
    ack_en = 1'b1;
    tick(3);
    checks++;
    if (acc !== 8'h08 || pc !== 8'h02 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_completes: acc=%h pc=%h req=%b, required 08 02 0", acc, pc, imem_req);
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    mem[8'h00] = 8'h05;
    mem[8'h01] = 8'h23;
    run = 1'b1;
    tick(6);
    checks++;
    if (retire !== 1'b1 || acc !== 8'h05) begin
      errors++;
      $display("FAIL pre_abort: retire=%b acc=%h, required 1 05", retire, acc);
    end
    snap = retire_cnt;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (acc !== 8'h00 || pc !== 8'h00 || retire !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: acc=%h pc=%h retire=%b req=%b, required 00 00 0 0",
               acc, pc, retire, imem_req);
    end
    tick(1);
    checks++;
    if (acc !== 8'h00 || retire_cnt !== snap) begin
      errors++;
      $display("FAIL abort_no_retire: acc=%h extra pulses=%0d, required 00 0", acc, retire_cnt - snap);
    end
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL restart: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    retire_cnt = 0;
    reset_n    = 1'b0;
    run        = 1'b0;
    ack_en     = 1'b0;
    r0         = 8'h00;
    r1         = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
    test_reset();
    test_load_add_hlt();
    test_reg_operand();
    test_pc_wrap_jmp();
    test_fetch_timeout();
    test_run_drop();
    test_reset_in_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one parameter, PC_RESET, default 8'h00, which is the pc value loaded on reset.
REQ-002 The block SHALL have one parameter, FETCH_TIMEOUT, default 15, which is the maximum number of FETCH cycles without imem_ack (range 1..255).
REQ-003 Port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, width 1: reset, asynchronous and active-low.
REQ-005 Port run, input, width 1: level-sensitive enable for instruction sequencing.
REQ-006 Port imem_req, output, width 1: instruction fetch request.
REQ-007 Port imem_addr, output, width 8: fetch address; always equals pc.
REQ-008 Port imem_ack, input, width 1: fetch complete; imem_rdata is valid in the same cycle.
REQ-009 Port imem_rdata, input, width 8: instruction byte with fields opcode[7:5], mode[4], field[3:0].
REQ-010 Port rf_rsel, output, width 1: register-file read select; equals ir[0].
REQ-011 Port rf_rdata, input, width 8: register-file read data, combinational from rf_rsel.
REQ-012 Port alu_a, output, width 8: ALU operand A; equals acc.
REQ-013 Port alu_b, output, width 8: ALU operand B; equals the operand register.
REQ-014 Port alu_ctrl, output, width 3: ALU operation; equals ir[7:5].
REQ-015 Port alu_result, input, width 8: combinational ALU result.
REQ-016 Port acc, output, width 8: accumulator value (the CPU output_data).
REQ-017 Port pc, output, width 8: program counter.
REQ-018 Port retire, output, width 1: one-cycle pulse per completed instruction.
REQ-019 Port halted, output, width 1: sticky indication that HLT was executed.
REQ-020 Port fault, output, width 1: sticky indication of a fetch timeout.

Function
REQ-021 The block SHALL implement the states IDLE, FETCH, DECODE, EXEC, HALT and FAULT.
REQ-022 IDLE SHALL go to FETCH when run=1 and stay in IDLE otherwise.
REQ-023 In FETCH, imem_req SHALL be 1; on imem_ack=1 the block SHALL latch ir<=imem_rdata and go to DECODE, otherwise it stays in FETCH.
REQ-024 The timeout counter SHALL clear on entry to FETCH and increment each FETCH cycle without ack; when it reaches FETCH_TIMEOUT the block SHALL go to FAULT with imem_req=0.
REQ-025 DECODE SHALL last one cycle and set operand <= (ir[4] ? rf_rdata : {4'b0,ir[3:0]}).
REQ-026 EXEC SHALL last one cycle, and for ADD/SUB/AND/OR/XOR (001-101) it SHALL set acc<=alu_result and pc<=pc+1.
REQ-027 In EXEC, LOAD (000) SHALL set acc<=operand and pc<=pc+1.
REQ-028 In EXEC, JMP (110) SHALL set pc<=operand and leave acc unchanged.
REQ-029 In EXEC, HLT (111) SHALL go to HALT with pc and acc unchanged.
REQ-030 pc+1 SHALL wrap from 8'hFF to 8'h00 without a flag.
REQ-031 retire SHALL be 1 for exactly the EXEC cycle of every instruction, HLT included.
REQ-032 After EXEC (non-HLT) the block SHALL go to FETCH if run=1 and to IDLE if run=0.
REQ-033 run falling mid-instruction SHALL NOT abort the instruction; a FETCH in progress SHALL complete.
REQ-034 imem_ack outside FETCH SHALL be ignored.
REQ-035 Minimum instruction latency with ack in the first FETCH cycle SHALL be 3 cycles (FETCH, DECODE, EXEC), giving back-to-back throughput of one instruction per 3 cycles.
REQ-036 HALT and FAULT SHALL be terminal until reset; halted=1 exactly in HALT and fault=1 exactly in FAULT.
REQ-037 imem_req SHALL be 0 in every state other than FETCH.

Reset
REQ-038 On reset_n=0, regardless of state, the block SHALL immediately set state=IDLE, pc=PC_RESET, acc=0, ir=0, operand=0, timeout counter=0, and imem_req=retire=halted=fault=0.
REQ-039 Reset asserted mid-fetch or mid-EXEC SHALL discard the instruction without updating acc.
REQ-040 The block SHALL leave reset on the first clk edge after reset_n=1.

Verification
REQ-041 Scenario: program 00:05 (LOAD #5), 01:23 (ADD #3), 02:E0 (HLT) with zero-wait ack and run=1 -> acc=5 then acc=8, 3 retire pulses, halted=1 with pc=02 and acc=8.
REQ-042 Scenario: rf r1=8'h0F, program 00:11 (LOAD r1), 01:6C (AND #C) -> acc=0F then acc=0C, rf_rsel=1 during DECODE of 00.
REQ-043 Scenario: pc=FE with 8'h21 at FE and FF -> pc goes FF then 00; JMP 8'hC3 -> pc=03 and acc unchanged.
REQ-044 Scenario: imem_ack held 0 with FETCH_TIMEOUT=15 -> fault=1 after 15 FETCH cycles, imem_req=0, and the block stays in FAULT while run toggles.
REQ-045 Scenario: run dropped during DECODE -> that instruction retires, then IDLE with no imem_req; run=1 resumes at pc+1.
REQ-046 Scenario: reset_n pulsed low during EXEC of ADD -> acc=0 and pc=PC_RESET asynchronously, no retire pulse.
